// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: reads the program counter, issues one memory read per PC,
// buffers the returned word and hands it to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_enable,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       fetch_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;

  state_e            state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic              xfer;

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = inst_valid_q;
  assign inst_data  = inst_data_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_cnt  = fetch_cnt_q;
  assign xfer       = inst_valid_q && inst_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= '0;
      req_pc_q     <= '0;
      inst_valid_q <= 1'b0;
      inst_data_q  <= '0;
      inst_pc_q    <= '0;
      fetch_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      imem_req_q   <= imem_req_d;
      imem_addr_q  <= imem_addr_d;
      req_pc_q     <= req_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_data_q  <= inst_data_d;
      inst_pc_q    <= inst_pc_d;
      fetch_cnt_q  <= fetch_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    imem_req_d   = 1'b0;
    imem_addr_d  = imem_addr_q;
    req_pc_d     = req_pc_q;
    inst_valid_d = inst_valid_q;
    inst_data_d  = inst_data_q;
    inst_pc_d    = inst_pc_q;
    fetch_cnt_d  = fetch_cnt_q;
    pc_enable    = 1'b0;

    if (flush) begin
      // A flush drops the buffered word and any response still in flight.
      inst_valid_d = 1'b0;
      case (state_q)
        WAIT:    state_d = imem_rvalid ? REQ : DISCARD;
        DISCARD: state_d = DISCARD;
        default: state_d = REQ;
      endcase
    end else begin
      if (xfer) begin
        inst_valid_d = 1'b0;
        fetch_cnt_d  = fetch_cnt_q + 32'd1;
      end
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          // Issue only when the single-entry buffer will be free to take the reply.
          if (!inst_valid_q || inst_ready) begin
            imem_req_d  = 1'b1;
            imem_addr_d = pc_in;
            req_pc_d    = pc_in;
            state_d     = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            inst_data_d  = imem_rdata;
            inst_pc_d    = req_pc_q;
            inst_valid_d = 1'b1;
            pc_enable    = 1'b1;
            state_d      = REQ;
          end
        end
        DISCARD: begin
          if (imem_rvalid) state_d = REQ;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: models the program counter, a variable-latency
// memory and the expected word stream to decode, and compares every cycle.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_enable;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [31:0] fetch_cnt;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_enable(pc_enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .flush(flush), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } word_t;

  int testCount = 0;
  int failCount = 0;

  // Reference model: words owed to decode, PC register, memory with one pending read.
  word_t       expQ[$];
  word_t       newWord;
  logic [31:0] pcModel, nextPc, jumpPc, expCnt, memAddr, memData;
  bit          busy, memDrop, reqNow, respNow, spur, expEn;
  int          memCnt, cycle, lastReqCycle, reqSeen, phaseReqs, idleCycles;
  int          latMin, latMax, readyPct, flushPct, spurPct;
  bit          checkRate, stopAfterReq;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic resetModel();
    expQ.delete();
    expCnt       = 32'd0;
    busy         = 1'b0;
    memDrop      = 1'b0;
    cycle        = 0;
    lastReqCycle = 0;
    reqSeen      = 0;
    phaseReqs    = 0;
    idleCycles   = 0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_pc_enable", 32'(pc_enable), 32'd0);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, 32'd0);
    checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
    checkOutput("rst_inst_data", inst_data, 32'd0);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    checkOutput("rst_fetch_cnt", fetch_cnt, 32'd0);
  endtask

  // Asserts reset away from any clock edge, checks outputs clear at once, releases on a negedge.
  task automatic applyReset(input logic [31:0] startPc);
    #2;
    reset       = 1'b1;
    flush       = 1'b0;
    inst_ready  = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    pcModel     = startPc;
    pc_in       = startPc;
    #1;
    checkResetOutputs();
    repeat (2) @(negedge clk);
    checkResetOutputs();
    reset = 1'b0;
    resetModel();
  endtask

  task automatic applyStimulus(input int nCycles);
    phaseReqs = 0;
    for (int n = 0; n < nCycles; n++) begin
      @(negedge clk);
      cycle++;
      checkOutput("inst_valid", 32'(inst_valid), 32'(expQ.size() != 0));
      if (expQ.size() != 0) begin
        checkOutput("inst_pc", inst_pc, expQ[0].pc);
        checkOutput("inst_data", inst_data, expQ[0].data);
      end
      checkOutput("fetch_cnt", fetch_cnt, expCnt);

      reqNow = imem_req;
      if (reqNow) begin
        checkOutput("imem_addr", imem_addr, pcModel);
        checkOutput("req_overlap", 32'(busy), 32'd0);
        if (checkRate) begin
          if (reqSeen == 0) checkOutput("first_req_cycle", 32'(cycle), 32'd2);
          else if (phaseReqs > 0) checkOutput("req_interval", 32'(cycle - lastReqCycle), 32'(2 + latMin));
        end
        reqSeen++;
        phaseReqs++;
        lastReqCycle = cycle;
      end

      respNow = 1'b0;
      if (busy) begin
        memCnt--;
        if (memCnt == 0) respNow = 1'b1;
      end
      spur        = !busy && !reqNow && ($urandom_range(0, 99) < spurPct);
      imem_rvalid = respNow || spur;
      imem_rdata  = respNow ? memData : $urandom();
      if (reqNow) begin
        busy    = 1'b1;
        memCnt  = $urandom_range(latMin, latMax);
        memAddr = pcModel;
        memData = $urandom();
        memDrop = 1'b0;
      end

      inst_ready = ($urandom_range(0, 99) < readyPct);
      flush      = !memDrop && ($urandom_range(0, 99) < flushPct);
      jumpPc     = $urandom_range(0, 63) << 2;
      #1;
      expEn = respNow && !memDrop && !flush;
      checkOutput("pc_enable", 32'(pc_enable), 32'(expEn));

      if (inst_valid && inst_ready || reqNow) idleCycles = 0;
      else idleCycles++;

      if (flush) begin
        expQ.delete();
        if (busy && !respNow) memDrop = 1'b1;
      end else begin
        if (inst_valid && inst_ready) begin
          if (expQ.size() != 0) void'(expQ.pop_front());
          expCnt = expCnt + 32'd1;
        end
        if (respNow && !memDrop) begin
          newWord.pc   = memAddr;
          newWord.data = memData;
          expQ.push_back(newWord);
        end
      end
      if (respNow) begin
        busy    = 1'b0;
        memDrop = 1'b0;
      end

      if (flush) nextPc = jumpPc;
      else if (pc_enable) nextPc = pcModel + 32'd4;
      else nextPc = pcModel;

      @(posedge clk);
      #1;
      pcModel     = nextPc;
      pc_in       = pcModel;
      flush       = 1'b0;
      imem_rvalid = 1'b0;

      if (idleCycles > 60) begin
        checkOutput("watchdog_idle", 32'(idleCycles), 32'd0);
        break;
      end
      if (stopAfterReq && reqSeen > 0 && cycle == lastReqCycle + 2) break;
    end
  endtask

  task automatic setKnobs(input int lmin, input int lmax, input int rdy, input int fl,
                          input int sp, input bit rate);
    latMin    = lmin;
    latMax    = lmax;
    readyPct  = rdy;
    flushPct  = fl;
    spurPct   = sp;
    checkRate = rate;
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    inst_ready   = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = 32'd0;
    pcModel      = 32'd0;
    pc_in        = 32'd0;
    stopAfterReq = 1'b0;
    memCnt       = 0;
    resetModel();
    repeat (2) @(negedge clk);
    checkResetOutputs();
    reset = 1'b0;

    // Latency 1 then 3 with decode always ready: fixed issue cadence of 2+L cycles.
    setKnobs(1, 1, 100, 0, 0, 1'b1);
    applyStimulus(20);
    setKnobs(3, 3, 100, 0, 0, 1'b1);
    applyStimulus(30);

    // Decode back-pressure: the buffered word must hold and no further request may go out.
    setKnobs(1, 1, 0, 0, 0, 1'b0);
    applyStimulus(8);
    setKnobs(1, 1, 100, 0, 0, 1'b0);
    applyStimulus(10);

    // Random latency, back-pressure, flushes and stray rvalid pulses.
    setKnobs(1, 4, 70, 8, 10, 1'b0);
    applyStimulus(1500);

    // Reset while a read is pending, then a clean refetch from a new PC.
    setKnobs(5, 5, 100, 0, 0, 1'b0);
    stopAfterReq = 1'b1;
    applyStimulus(100);
    stopAfterReq = 1'b0;
    applyReset(32'h0000_0100);
    setKnobs(2, 2, 100, 0, 0, 1'b1);
    applyStimulus(30);

    setKnobs(1, 3, 60, 12, 5, 1'b0);
    applyStimulus(1000);
    checkOutput("progress", 32'(expCnt > 32'd20), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
